// File: rtl/al4s3b_fpga_onion_uarttx.sv
// ---------------------------------------------------------------------------
// al4s3b_fpga_onion_uarttx
//
// Wishbone-slave UART transmitter with a TX FIFO and 8N1 framing.
//
// Register map (byte offset, only WBs_ADR_i[9:2] decoded):
//   0x00 TXDATA  (W)      push WBs_DAT_i[7:0] when byte lane 0 is enabled
//   0x04 CTRL    (RW)     [0] EN, [1] IRQEN
//   0x08 BAUDDIV (RW)     [15:0], bit period = BAUDDIV+1 clocks
//   0x0C STATUS  (R/W1C)  [6:0] COUNT, [8] FULL, [9] EMPTY, [10] BUSY,
//                         [11] OVF (write 1 to clear)
//   other offsets read DEFAULT_READ_VALUE
//
// Ports:
//   WBs_CLK_i       clock for all logic
//   WBs_RST_i       synchronous active-high reset
//   WBs_ADR_i       byte address
//   WBs_CYC_i       chip-select from the IP aggregator
//   WBs_BYTE_STB_i  byte enables
//   WBs_WE_i        write enable
//   WBs_STB_i       transfer strobe
//   WBs_DAT_i       write data
//   WBs_DAT_o       read data (combinational)
//   WBs_ACK_o       one-cycle transfer acknowledge
//   UART_TX_o       serial output, idle high
//   TX_IRQ_o        level IRQ: IRQEN & FIFO empty & FSM idle
// ---------------------------------------------------------------------------
module al4s3b_fpga_onion_uarttx #(
   parameter int          FIFO_DEPTH         = 16,
   parameter logic [15:0] DEFAULT_BAUDDIV    = 16'd103,
   parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
   input  logic        WBs_CLK_i,
   input  logic        WBs_RST_i,
   input  logic [16:0] WBs_ADR_i,
   input  logic        WBs_CYC_i,
   input  logic [3:0]  WBs_BYTE_STB_i,
   input  logic        WBs_WE_i,
   input  logic        WBs_STB_i,
   input  logic [31:0] WBs_DAT_i,
   output logic [31:0] WBs_DAT_o,
   output logic        WBs_ACK_o,
   output logic        UART_TX_o,
   output logic        TX_IRQ_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

   localparam logic [7:0] SEL_TXDATA  = 8'h00;
   localparam logic [7:0] SEL_CTRL    = 8'h01;
   localparam logic [7:0] SEL_BAUDDIV = 8'h02;
   localparam logic [7:0] SEL_STATUS  = 8'h03;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Address/data bits that the register map never looks at.
   logic unused_bits;
   assign unused_bits = ^{WBs_ADR_i[16:10], WBs_ADR_i[1:0],
                          WBs_BYTE_STB_i[3:2], WBs_DAT_i[31:16]};

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic [7:0] reg_sel;
   logic       wr_cyc;

   assign reg_sel = WBs_ADR_i[9:2];
   // The ACK term makes each transfer commit exactly once.
   assign wr_cyc  = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~WBs_ACK_o;

   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) WBs_ACK_o <= 1'b0;
      else           WBs_ACK_o <= WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
   end

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   logic        en;
   logic        irqen;
   logic [15:0] bauddiv;

   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         en      <= 1'b0;
         irqen   <= 1'b0;
         bauddiv <= DEFAULT_BAUDDIV;
      end else if (wr_cyc) begin
         if (reg_sel == SEL_CTRL && WBs_BYTE_STB_i[0]) begin
            en    <= WBs_DAT_i[0];
            irqen <= WBs_DAT_i[1];
         end
         if (reg_sel == SEL_BAUDDIV) begin
            if (WBs_BYTE_STB_i[0]) bauddiv[7:0]  <= WBs_DAT_i[7:0];
            if (WBs_BYTE_STB_i[1]) bauddiv[15:8] <= WBs_DAT_i[15:8];
         end
      end
   end

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          ovf;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          ovf_clr;

   assign full     = (count == CNT_MAX);
   assign empty    = (count == '0);
   assign push_req = wr_cyc & (reg_sel == SEL_TXDATA) & WBs_BYTE_STB_i[0];
   // Fullness is judged before any same-cycle pop, so a push into a full
   // FIFO is always dropped.
   assign push     = push_req & ~full;
   assign ovf_clr  = wr_cyc & (reg_sel == SEL_STATUS) &
                     WBs_BYTE_STB_i[1] & WBs_DAT_i[11];

   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (push_req && full) ovf <= 1'b1;
         else if (ovf_clr)     ovf <= 1'b0;
      end
   end

   always_ff @(posedge WBs_CLK_i) begin
      if (push) mem[wr_ptr] <= WBs_DAT_i[7:0];
   end

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   state_t      state;
   logic [15:0] baud_cnt;
   logic [15:0] bit_div;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        bit_end;
   logic        start_ok;

   assign bit_end  = (baud_cnt == bit_div);
   assign start_ok = en & ~empty;
   assign pop      = start_ok & ((state == IDLE) || (state == STOP && bit_end));

   // Divisor is sampled at each bit start so a mid-frame BAUDDIV write
   // only changes the following bit.
   always_ff @(posedge WBs_CLK_i) begin
      if (pop) shift <= mem[rd_ptr];
      if (pop || (state != IDLE && bit_end)) bit_div <= bauddiv;
   end

   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         state     <= IDLE;
         UART_TX_o <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               UART_TX_o <= 1'b1;
               if (pop) begin
                  state     <= START;
                  UART_TX_o <= 1'b0;
                  baud_cnt  <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  state     <= DATA;
                  UART_TX_o <= shift[0];
                  baud_cnt  <= '0;
                  bit_idx   <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state     <= STOP;
                     UART_TX_o <= 1'b1;
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     UART_TX_o <= shift[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  // Back-to-back frames: no idle bit between stop and start.
                  if (pop) begin
                     state     <= START;
                     UART_TX_o <= 1'b0;
                  end else begin
                     state     <= IDLE;
                     UART_TX_o <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               state     <= IDLE;
               UART_TX_o <= 1'b1;
            end
         endcase
      end
   end

   assign TX_IRQ_o = irqen & empty & (state == IDLE);

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   logic [6:0] count7;
   logic       busy;

   assign count7 = 7'(count);
   assign busy   = (state != IDLE);

   always_comb begin
      WBs_DAT_o = DEFAULT_READ_VALUE;
      case (reg_sel)
         SEL_TXDATA:  WBs_DAT_o = 32'h0;
         SEL_CTRL:    WBs_DAT_o = {30'h0, irqen, en};
         SEL_BAUDDIV: WBs_DAT_o = {16'h0, bauddiv};
         SEL_STATUS:  WBs_DAT_o = {20'h0, ovf, busy, empty, full, 1'b0, count7};
         default:     WBs_DAT_o = DEFAULT_READ_VALUE;
      endcase
   end

endmodule

// File: tb/tb_al4s3b_fpga_onion_uarttx.sv
// ---------------------------------------------------------------------------
// tb_al4s3b_fpga_onion_uarttx
//
// Directed bench for the UART TX block: register access, framing at
// several divisors, FIFO overflow, back-to-back frames, mid-frame reset
// and the idle interrupt.
// ---------------------------------------------------------------------------
module tb_al4s3b_fpga_onion_uarttx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] adr = '0;
   logic        cyc = 1'b0;
   logic [3:0]  bstb = '0;
   logic        we = 1'b0;
   logic        stb = 1'b0;
   logic [31:0] dat_w = '0;
   logic [31:0] dat_r;
   logic        ack;
   logic        tx;
   logic        irq;

   int cmp_cnt = 0;
   int err_cnt = 0;

   localparam logic [16:0] A_TXDATA  = 17'h00;
   localparam logic [16:0] A_CTRL    = 17'h04;
   localparam logic [16:0] A_BAUDDIV = 17'h08;
   localparam logic [16:0] A_STATUS  = 17'h0C;

   al4s3b_fpga_onion_uarttx #(
      .FIFO_DEPTH(16),
      .DEFAULT_BAUDDIV(16'd103),
      .DEFAULT_READ_VALUE(32'hBAD_FAB_AC)
   ) dut (
      .WBs_CLK_i(clk),
      .WBs_RST_i(rst),
      .WBs_ADR_i(adr),
      .WBs_CYC_i(cyc),
      .WBs_BYTE_STB_i(bstb),
      .WBs_WE_i(we),
      .WBs_STB_i(stb),
      .WBs_DAT_i(dat_w),
      .WBs_DAT_o(dat_r),
      .WBs_ACK_o(ack),
      .UART_TX_o(tx),
      .TX_IRQ_o(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; bstb = be;
      @(posedge clk); #1;
      chk("wr_ack", {31'h0, ack}, 32'h1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; bstb = '0;
   endtask

   task automatic wb_read(input logic [16:0] a, output logic [31:0] d);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; bstb = 4'hF;
      #1;
      d = dat_r;
      chk("rd_ack_early", {31'h0, ack}, 32'h0);
      @(posedge clk); #1;
      chk("rd_ack", {31'h0, ack}, 32'h1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; bstb = '0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [9:0]  f10;
      logic [19:0] f20;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", {31'h0, tx}, 32'h1);
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      @(negedge clk); rst = 1'b0;
      wb_read(A_STATUS, rd);  chk("rst_status", rd, 32'h0000_0200);
      wb_read(A_CTRL, rd);    chk("rst_ctrl", rd, 32'h0);
      wb_read(A_BAUDDIV, rd); chk("rst_bauddiv", rd, 32'd103);
      wb_read(A_TXDATA, rd);  chk("txdata_read", rd, 32'h0);

      // Unmapped offsets
      wb_read(17'h010, rd); chk("unmapped_10", rd, 32'hBADFABAC);
      wb_read(17'h3FC, rd); chk("unmapped_3fc", rd, 32'hBADFABAC);

      // Byte-lane gating
      wb_write(A_BAUDDIV, 32'h0000_1234, 4'b0010);
      wb_read(A_BAUDDIV, rd); chk("bauddiv_lane1", rd, 32'h0000_1267);
      wb_write(A_TXDATA, 32'h0000_0055, 4'b1110);
      wb_read(A_STATUS, rd); chk("txdata_lane0_off", rd, 32'h0000_0200);
      wb_write(A_CTRL, 32'hFFFF_FFFF, 4'b0001);
      wb_read(A_CTRL, rd); chk("ctrl_bits", rd, 32'h3);
      wb_write(A_CTRL, 32'h0, 4'b0001);

      // Single frame 0xA5 at BAUDDIV=3
      wb_write(A_BAUDDIV, 32'd3, 4'b0011);
      wb_write(A_CTRL, 32'h1, 4'b0001);
      wb_write(A_TXDATA, 32'hA5, 4'b0001);
      f10 = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         chk($sformatf("a5_bit%0d", k), {31'h0, tx}, {31'h0, f10[k / 4]});
      end
      @(posedge clk); #1;
      chk("a5_idle", {31'h0, tx}, 32'h1);
      wb_read(A_STATUS, rd); chk("a5_status", rd, 32'h0000_0200);

      // Overflow with EN=0
      wb_write(A_CTRL, 32'h0, 4'b0001);
      for (int i = 0; i < 17; i++) wb_write(A_TXDATA, 32'(i), 4'b0001);
      wb_read(A_STATUS, rd); chk("ovf_status", rd, 32'h0000_0910);
      wb_write(A_STATUS, 32'h0000_0800, 4'b1111);
      wb_read(A_STATUS, rd); chk("ovf_cleared", rd, 32'h0000_0110);
      do_reset();
      wb_read(A_STATUS, rd); chk("reset_fifo", rd, 32'h0000_0200);

      // Back-to-back frames at BAUDDIV=0
      wb_write(A_BAUDDIV, 32'd0, 4'b0011);
      wb_write(A_TXDATA, 32'h00, 4'b0001);
      wb_write(A_TXDATA, 32'hFF, 4'b0001);
      wb_write(A_CTRL, 32'h1, 4'b0001);
      f20 = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b_bit%0d", k), {31'h0, tx}, {31'h0, f20[k]});
      end
      @(posedge clk); #1;
      chk("b2b_idle", {31'h0, tx}, 32'h1);
      wb_read(A_STATUS, rd); chk("b2b_status", rd, 32'h0000_0200);

      // Reset during data bit 3
      wb_write(A_BAUDDIV, 32'd3, 4'b0011);
      wb_write(A_TXDATA, 32'hA5, 4'b0001);
      repeat (18) @(posedge clk);
      #1;
      chk("mid_bit3", {31'h0, tx}, 32'h0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_tx", {31'h0, tx}, 32'h1);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_after_tx", {31'h0, tx}, 32'h1);
      wb_read(A_STATUS, rd);  chk("mid_status", rd, 32'h0000_0200);
      wb_read(A_BAUDDIV, rd); chk("mid_bauddiv", rd, 32'd103);
      wb_read(A_CTRL, rd);    chk("mid_ctrl", rd, 32'h0);

      // Idle interrupt at BAUDDIV=1
      wb_write(A_BAUDDIV, 32'd1, 4'b0011);
      wb_write(A_CTRL, 32'h3, 4'b0001);
      chk("irq_empty_idle", {31'h0, irq}, 32'h1);
      wb_write(A_TXDATA, 32'h5A, 4'b0001);
      chk("irq_queued", {31'h0, irq}, 32'h0);
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk); #1;
         chk($sformatf("irq_cyc%0d", k), {31'h0, irq}, (k == 21) ? 32'h1 : 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/al4s3b_fpga_onion_uarttx.md
AL4S3B_FPGA_ONION_UARTTX -- requirements
Module: al4s3b_fpga_onion_uarttx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DEFAULT_BAUDDIV, default 16'd103, BAUDDIV reset value.
REQ-003 SHALL have parameter DEFAULT_READ_VALUE, default 32'hBAD_FAB_AC, read value for unmapped offsets.
REQ-004 WBs_CLK_i  input  1  sole clock for all logic.
REQ-005 WBs_RST_i  input  1  reset, synchronous, active-high.
REQ-006 WBs_ADR_i  input  17  Wishbone byte address; only [9:2] decoded.
REQ-007 WBs_CYC_i  input  1  module chip-select, pre-decoded by the IP aggregator.
REQ-008 WBs_BYTE_STB_i  input  4  byte enables.
REQ-009 WBs_WE_i  input  1  write enable.
REQ-010 WBs_STB_i  input  1  transfer strobe.
REQ-011 WBs_DAT_i  input  32  write data.
REQ-012 WBs_DAT_o  output  32  read data.
REQ-013 WBs_ACK_o  output  1  transfer acknowledge.
REQ-014 UART_TX_o  output  1  serial line, idle high.
REQ-015 TX_IRQ_o  output  1  level interrupt, asserted when IRQEN=1 and FIFO empty and FSM IDLE.

Function
REQ-016 SHALL register WBs_ACK_o <= CYC & STB & ~WBs_ACK_o: one-cycle pulse, one clock after strobe, one ACK per transfer.
REQ-017 SHALL commit a write only on the cycle CYC & STB & WE & ~WBs_ACK_o, exactly once per transfer.
REQ-018 Register map (byte offset): 0x00 TXDATA (W), 0x04 CTRL (RW), 0x08 BAUDDIV (RW), 0x0C STATUS (R / W1C).
REQ-019 TXDATA write with BYTE_STB[0]=1 SHALL push WBs_DAT_i[7:0]; BYTE_STB[0]=0 SHALL be ignored; TXDATA reads return 0.
REQ-020 CTRL: [0] EN, [1] IRQEN; other bits read 0; byte lane 0 gates the write.
REQ-021 BAUDDIV [15:0], byte lanes 0/1 independently written; bit period = BAUDDIV+1 clocks; BAUDDIV=0 gives 1 clock/bit.
REQ-022 STATUS: [6:0] COUNT, [8] FULL, [9] EMPTY, [10] BUSY (FSM not IDLE), [11] OVF (sticky); writing 1 to bit 11 clears OVF; other bits read 0.
REQ-023 Reads of unmapped offsets SHALL return DEFAULT_READ_VALUE; WBs_DAT_o SHALL be a combinational function of WBs_ADR_i[9:2] and register state.
REQ-024 Push while FULL SHALL drop the byte and set OVF, even if a pop occurs the same cycle.
REQ-025 Push and pop in the same cycle when not full SHALL leave COUNT unchanged and keep FIFO order.
REQ-026 FSM states: IDLE, START, DATA, STOP.
REQ-027 IDLE->START when EN=1 and FIFO not empty; pop the head byte into the shift register on that transition.
REQ-028 START drives 0 for one bit period, then goes to DATA.
REQ-029 DATA drives 8 bits LSB first, one bit period each, using a 3-bit bit index.
REQ-030 STOP drives 1 for one bit period.
REQ-031 STOP->START directly, with no idle bit, if EN=1 and FIFO is non-empty at the end of the stop bit; otherwise STOP->IDLE.
REQ-032 The baud counter SHALL reload to 0 on every state entry and count to BAUDDIV.
REQ-033 A BAUDDIV write mid-frame SHALL take effect at the next bit boundary.
REQ-034 EN cleared mid-frame SHALL let the current frame finish; no further pops until EN=1.
REQ-035 UART_TX_o SHALL be registered and equal 1 in IDLE.

Reset
REQ-036 On WBs_RST_i=1 at a clock edge, regardless of FSM state:
- FIFO emptied (COUNT=0, EMPTY=1, FULL=0), OVF=0
- CTRL=0, BAUDDIV=DEFAULT_BAUDDIV
- FSM=IDLE, UART_TX_o=1, WBs_ACK_o=0, TX_IRQ_o=0
REQ-037 Reset asserted mid-frame SHALL abort the frame; the line is high on the first cycle after reset.

Verification
REQ-038 BAUDDIV=3, EN=1, write TXDATA 0xA5 -> UART_TX_o: 0 for 4 clk, then 1,0,1,0,0,1,0,1 at 4 clk each, then 1 for 4 clk; BUSY=0 afterwards.
REQ-039 EN=0, write 17 bytes with FIFO_DEPTH=16 -> STATUS reads COUNT=16, FULL=1, OVF=1; write 0x800 to STATUS -> OVF=0 with COUNT unchanged.
REQ-040 BAUDDIV=0, EN=1, queue 0x00 and 0xFF -> 20 back-to-back bit periods of 1 clk with no idle gap; EMPTY=1 at the end.
REQ-041 Read offsets 0x10 and 0x3FC -> 0xBADFABAC; each transfer ACKs exactly one cycle after strobe.
REQ-042 Assert reset during bit 3 of a frame -> UART_TX_o=1 the next cycle, COUNT=0, BAUDDIV=103.
REQ-043 IRQEN=1, EN=1, one byte queued -> TX_IRQ_o=0 while sending, rises on the cycle the FSM returns to IDLE.
